// File: rtl/amem_wadr_pipe.sv
// A-memory address control: delayed-write address pipeline of DEPTH stages,
// A-memory address mux, read/write pulses and read-after-pending-write bypass flags.
module amem_wadr_pipe #(
  parameter  int AW     = 10,
  parameter  int MW     = 5,
  parameter  int IR_W   = 49,
  parameter  int RA_LSB = 32,
  parameter  int WA_LSB = 14,
  parameter  int DEPTH  = 1,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            state_decode,
  input  logic            state_write,
  input  logic            destm,
  input  logic            dest,
  input  logic            flush,
  input  logic [IR_W-1:0] ir,
  output logic [AW-1:0]   wadr,
  output logic [AW-1:0]   aadr,
  output logic            awp,
  output logic            arp,
  output logic            byp_hit,
  output logic [IW-1:0]   byp_idx,
  output logic [PW-1:0]   pending
);

  logic [AW-1:0]    addr_reg  [DEPTH];
  logic [AW-1:0]    addr_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [PW-1:0]    pending_reg;
  logic [PW-1:0]    pending_next;
  logic [AW-1:0]    cap_addr;
  logic [AW-1:0]    rd_addr;
  logic             unused_ir;

  assign unused_ir = ^ir;
  assign rd_addr   = ir[RA_LSB+AW-1:RA_LSB];
  assign cap_addr  = destm ? {{(AW-MW){1'b0}}, ir[WA_LSB+MW-1:WA_LSB]}
                           : ir[WA_LSB+AW-1:WA_LSB];

  // Per-stage next state: flush clears valid but never shifts; decode shifts,
  // and a write retires the oldest stage unless decode shifts a new one in.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic          src_valid;
    logic [AW-1:0] src_addr;
    logic          retire;

    if (gi == 0) begin : g_head
      assign src_valid = dest;
      assign src_addr  = cap_addr;
    end else begin : g_body
      assign src_valid = valid_reg[gi-1];
      assign src_addr  = addr_reg[gi-1];
    end

    assign retire         = (gi == DEPTH - 1) && state_write;
    assign valid_next[gi] = flush        ? 1'b0 :
                            state_decode ? src_valid :
                            retire       ? 1'b0 : valid_reg[gi];
    assign addr_next[gi]  = (state_decode && !flush) ? src_addr : addr_reg[gi];
  end

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_next = pending_next + PW'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg    <= '{default: '0};
      valid_reg   <= '0;
      pending_reg <= '0;
    end else begin
      addr_reg    <= addr_next;
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
    end
  end

  // Descending scan so the lowest (newest) matching stage wins.
  always_comb begin
    byp_hit = 1'b0;
    byp_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_reg[i] && (addr_reg[i] == rd_addr)) begin
        byp_hit = 1'b1;
        byp_idx = IW'(i);
      end
    end
  end

  assign wadr    = addr_reg[DEPTH-1];
  assign awp     = state_write & valid_reg[DEPTH-1];
  assign arp     = state_decode;
  assign aadr    = state_write ? wadr : rd_addr;
  assign pending = pending_reg;

endmodule

// File: tb/tb_amem_wadr_pipe.sv
// Scoreboard bench for amem_wadr_pipe at DEPTH 1, 2 and 3 sharing one stimulus bus.
module tb_amem_wadr_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        state_decode = 1'b0;
  logic        state_write = 1'b0;
  logic        destm = 1'b0;
  logic        dest = 1'b0;
  logic        flush = 1'b0;
  logic [48:0] ir = '0;

  logic [9:0] wadr1, aadr1, wadr2, aadr2, wadr3, aadr3;
  logic       awp1, arp1, awp2, arp2, awp3, arp3;
  logic       hit1, hit2, hit3;
  logic       idx1, idx2;
  logic [1:0] idx3;
  logic       pen1;
  logic [1:0] pen2, pen3;

  amem_wadr_pipe #(.DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .state_decode(state_decode), .state_write(state_write),
    .destm(destm), .dest(dest), .flush(flush), .ir(ir),
    .wadr(wadr1), .aadr(aadr1), .awp(awp1), .arp(arp1),
    .byp_hit(hit1), .byp_idx(idx1), .pending(pen1)
  );
  amem_wadr_pipe #(.DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .state_decode(state_decode), .state_write(state_write),
    .destm(destm), .dest(dest), .flush(flush), .ir(ir),
    .wadr(wadr2), .aadr(aadr2), .awp(awp2), .arp(arp2),
    .byp_hit(hit2), .byp_idx(idx2), .pending(pen2)
  );
  amem_wadr_pipe #(.DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .state_decode(state_decode), .state_write(state_write),
    .destm(destm), .dest(dest), .flush(flush), .ir(ir),
    .wadr(wadr3), .aadr(aadr3), .awp(awp3), .arp(arp3),
    .byp_hit(hit3), .byp_idx(idx3), .pending(pen3)
  );

  always #5 clk = ~clk;

  localparam int F_WADR = 0, F_AADR = 1, F_AWP = 2, F_ARP = 3, F_HIT = 4, F_IDX = 5, F_PEN = 6;

  typedef struct {
    int    cyc;
    string nm;
    int    d;
    int    f;
    int    v;
  } exp_t;

  exp_t sbq[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int get(input int d, input int f);
    int r;
    r = -1;
    case (d)
      1: case (f)
           F_WADR: r = int'(wadr1); F_AADR: r = int'(aadr1); F_AWP: r = int'(awp1);
           F_ARP:  r = int'(arp1);  F_HIT:  r = int'(hit1);  F_IDX: r = int'(idx1);
           F_PEN:  r = int'(pen1);  default: r = -1;
         endcase
      2: case (f)
           F_WADR: r = int'(wadr2); F_AADR: r = int'(aadr2); F_AWP: r = int'(awp2);
           F_ARP:  r = int'(arp2);  F_HIT:  r = int'(hit2);  F_IDX: r = int'(idx2);
           F_PEN:  r = int'(pen2);  default: r = -1;
         endcase
      default: case (f)
           F_WADR: r = int'(wadr3); F_AADR: r = int'(aadr3); F_AWP: r = int'(awp3);
           F_ARP:  r = int'(arp3);  F_HIT:  r = int'(hit3);  F_IDX: r = int'(idx3);
           F_PEN:  r = int'(pen3);  default: r = -1;
         endcase
    endcase
    return r;
  endfunction

  // Monitor: compares every expectation queued for the current cycle mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
      e   = sbq.pop_front();
      act = get(e.d, e.f);
      checks++;
      if (e.cyc != cycle || act != e.v) begin
        errors++;
        $display("FAIL %s (depth%0d): got 0x%0h required 0x%0h", e.nm, e.d, act, e.v);
      end else begin
        $display("ok   %s (depth%0d): 0x%0h", e.nm, e.d, act);
      end
    end
  end

  task automatic chk(input string nm, input int d, input int f, input int v);
    exp_t e;
    e.cyc = cycle; e.nm = nm; e.d = d; e.f = f; e.v = v;
    sbq.push_back(e);
  endtask

  function automatic logic [48:0] mk_ir(input int ra, input int wa);
    logic [48:0] r;
    r = '0;
    r[41:32] = ra[9:0];
    r[23:14] = wa[9:0];
    return r;
  endfunction

  task automatic drive(input bit dec, input bit wr, input bit fl, input bit rs,
                       input bit de, input bit dm, input int wa, input int ra);
    state_decode = dec; state_write = wr; flush = fl; reset = rs;
    dest = de; destm = dm; ir = mk_ir(ra, wa);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    do_reset();
    checks++;
    if (wadr2 !== 10'h000 || pen2 !== 2'd0) begin
      errors++;
      $display("FAIL rst_direct (depth2): wadr=0x%0h pending=%0d required 0/0", wadr2, pen2);
    end else begin
      $display("ok   rst_direct (depth2): wadr=0x%0h pending=%0d", wadr2, pen2);
    end
    chk("rst_wadr", 1, F_WADR, 0); chk("rst_pend", 1, F_PEN, 0);
    chk("rst_hit", 3, F_HIT, 0);   chk("rst_idx", 3, F_IDX, 0);
    chk("rst_pend", 3, F_PEN, 0);
    tick();

    // single-latch decode then write
    drive(1, 0, 0, 0, 1, 0, 'h2A5, 'h155);
    chk("t1_arp", 1, F_ARP, 1); chk("t1_aadr_rd", 1, F_AADR, 'h155); chk("t1_awp_dec", 1, F_AWP, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 'h155);
    chk("t1_wadr", 1, F_WADR, 'h2A5); chk("t1_awp", 1, F_AWP, 1);
    chk("t1_aadr_wr", 1, F_AADR, 'h2A5); chk("t1_pend", 1, F_PEN, 1); chk("t1_arp0", 1, F_ARP, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_awp_idle", 1, F_AWP, 0); chk("t1_pend_after", 1, F_PEN, 0);
    tick();

    // short destination, write only once
    do_reset();
    drive(1, 0, 0, 0, 1, 1, 'h3F3, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_wadr", 1, F_WADR, 'h013); chk("t2_awp", 1, F_AWP, 1);
    tick();
    chk("t2_awp_again", 1, F_AWP, 0); chk("t2_aadr", 1, F_AADR, 'h013);
    tick();

    // decode and write together at DEPTH=1
    drive(1, 0, 0, 0, 1, 0, 'h0AB, 0);
    tick();
    drive(1, 1, 0, 0, 1, 0, 'h0CD, 0);
    chk("dw_awp", 1, F_AWP, 1); chk("dw_aadr", 1, F_AADR, 'h0AB);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dw_wadr", 1, F_WADR, 'h0CD); chk("dw_pend", 1, F_PEN, 1);
    tick();

    // DEPTH=3 bypass, newest match wins
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 'h10, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 'h20, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 'h10, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 'h10);
    chk("t3_pend", 3, F_PEN, 3); chk("t3_hit10", 3, F_HIT, 1);
    chk("t3_idx10", 3, F_IDX, 0); chk("t3_wadr", 3, F_WADR, 'h10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 'h20);
    chk("t3_hit20", 3, F_HIT, 1); chk("t3_idx20", 3, F_IDX, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 'h30);
    chk("t3_hit30", 3, F_HIT, 0); chk("t3_idx30", 3, F_IDX, 0);
    tick();

    // DEPTH=2 non-writing entry reaches the oldest stage
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 'h55, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 'h66, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t4_awp", 2, F_AWP, 0); chk("t4_wadr", 2, F_WADR, 'h55); chk("t4_pend", 2, F_PEN, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_pend_after", 2, F_PEN, 1);
    tick();

    // flush with write and decode in one cycle
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 'h11, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 'h22, 0); tick();
    drive(1, 1, 1, 0, 1, 0, 'h33, 'h22);
    chk("t5_awp", 2, F_AWP, 1); chk("t5_aadr", 2, F_AADR, 'h11); chk("t5_pend_pre", 2, F_PEN, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 'h11);
    chk("t5_pend", 2, F_PEN, 0); chk("t5_hit", 2, F_HIT, 0); chk("t5_wadr_kept", 2, F_WADR, 'h11);
    tick();

    // reset mid-pipeline
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 'h44, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 'h77, 0); tick();
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    chk("t6_pend_pre", 2, F_PEN, 2);
    tick();
    checks++;
    if (wadr2 !== 10'h000 || pen2 !== 2'd0) begin
      errors++;
      $display("FAIL t6_direct (depth2): wadr=0x%0h pending=%0d required 0/0", wadr2, pen2);
    end else begin
      $display("ok   t6_direct (depth2): wadr=0x%0h pending=%0d", wadr2, pen2);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t6_wadr", 2, F_WADR, 0); chk("t6_pend", 2, F_PEN, 0); chk("t6_awp", 2, F_AWP, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s (depth%0d): never compared, required 0x%0h", e.nm, e.d, e.v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
